udma_filter_sched: RTL and testbench
====================================

// Module: udma_filter_sched
// PURPOSE
//  Sequencer for the uDMA filter datapath: TX0/TX1 streamers, arithmetic unit (AU), binarisation counter (BINCU), RX streamer.
//  On a start pulse from the filter config regs, it decodes the filter mode, launches the required channels and tracks their done flags.
//  After the last done it drains the datapath pipeline, then reports completion, abort or timeout as single-cycle events.
//  Sits between the filter configuration registers and the filter datapath.
// PARAMETERS
//  DRAIN_CYCLES  4   cycles waited after last done for AU/BINCU pipeline flush (>=1)
//  TIMEOUT_W     16  width of watchdog counter / cfg_timeout_i
// PORTS
//  clk_i              in   1          clock
//  rst_i              in   1          synchronous reset, active high
//  cfg_filter_mode_i  in   3          filter mode, sampled on accepted start
//  cfg_filter_start_i in   1          start pulse
//  cfg_abort_i        in   1          abort request (level, acted on when seen)
//  cfg_timeout_i      in   TIMEOUT_W  max RUN cycles without any done; 0 = watchdog off
//  tx0_start_o        out  1          launch TX channel 0 (1-cycle pulse)
//  tx1_start_o        out  1          launch TX channel 1 (1-cycle pulse)
//  rx_start_o         out  1          launch RX channel (1-cycle pulse)
//  tx0_done_i         in   1          TX0 finished (pulse)
//  tx1_done_i         in   1          TX1 finished (pulse)
//  rx_done_i          in   1          RX finished (pulse)
//  au_en_o            out  1          AU in path (else bypass); held while busy
//  bincu_en_o         out  1          BINCU in path; held while busy
//  bincu_evt_i        in   1          BINCU threshold reached (pulse)
//  busy_o             out  1          state != IDLE
//  evt_done_o         out  1          1-cycle pulse: filter completed
//  evt_err_o          out  1          1-cycle pulse: bad mode, timeout or start-while-busy
//  evt_bincu_o        out  1          bincu_evt_i gated by busy_o & bincu_en_o
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, sticky done flags and counters cleared.
//  Mode decode (need_tx0/need_tx1/au/bincu/need_rx):
//   0 TX0->RX; 1 TX0->BINCU->RX; 2 TX0,TX1->AU->RX; 3 TX0,TX1->AU->BINCU->RX;
//   4 TX0->AU->RX; 5 TX0->AU->BINCU->RX; 6 TX0->BINCU (no RX); 7 illegal.
//  IDLE: start with mode 7 -> evt_err_o next cycle, stay IDLE.
//   Start with any other mode -> latch mode, go to ARM.
//  ARM (1 cycle): pulse the start outputs of the required channels together; clear sticky dones; go to RUN.
//   au_en_o/bincu_en_o are asserted from ARM through DONE.
//  RUN: per-channel sticky flag set on its done pulse; done pulses of unused channels are ignored.
//   A done arriving in the ARM cycle is captured.
//   Leave to DRAIN in the cycle after all required flags are set.
//  DRAIN: count DRAIN_CYCLES cycles, then go to DONE. DONE: evt_done_o=1 for 1 cycle, then IDLE.
//   Start-to-evt_done latency with all dones at RUN entry = DRAIN_CYCLES+3 cycles.
//  Watchdog: counter runs only in RUN and reloads to 0 on any required done.
//   When cfg_timeout_i!=0 and counter==cfg_timeout_i-1: evt_err_o pulse, go to IDLE, no evt_done_o.
//   The counter saturates and does not wrap.
//  Abort: cfg_abort_i in any non-IDLE state -> IDLE next cycle; no done event, no err event.
//   Abort has priority over timeout and completion in the same cycle.
//  Start while busy: ignored; evt_err_o pulse; running job unaffected.
//  Start and abort in the same cycle in IDLE: start wins (abort is a no-op in IDLE).
//  rst_i mid-operation: immediate return to IDLE on the next edge; no events emitted.
// STRUCTURE
//  Package udma_filter_pkg: typedef enum filt_state_e {IDLE,ARM,RUN,DRAIN,DONE}.
//  Package udma_filter_pkg: filt_mode_e (0..7) and struct filt_route_t {tx0,tx1,au,bincu,rx}.
//  Package udma_filter_pkg: function decode_mode() returning filt_route_t.
//  Sub-module udma_filter_wdog: loadable saturating counter plus compare, with clear/enable/expire.
//  FSM, sticky flags and drain counter stay in this module.
// TESTING
//  mode 2, tx0_done@+5, tx1_done@+9, rx_done@+12 -> evt_done 1 cycle at rx_done+1+DRAIN_CYCLES+1; au_en=1, bincu_en=0 throughout.
//  mode 7 start -> evt_err pulse next cycle, busy_o stays 0, no start pulses.
//  mode 0, cfg_timeout=10, no dones -> evt_err at 10th RUN cycle, back to IDLE; with cfg_timeout=0 -> hangs busy until abort.
//  mode 6 running, second start -> evt_err pulse; tx0_done -> evt_done; rx_done injected is ignored.
//  mode 3, bincu_evt_i pulse while busy -> evt_bincu pulse; same pulse in mode 0 or IDLE -> none.
//  mode 1, abort in the same cycle as final rx_done -> IDLE, no evt_done/evt_err; rst_i in DRAIN -> IDLE, outputs 0.

Source files
------------

// File: rtl/udma_filter_pkg.sv
// Purpose : shared types and mode-to-route decode for the uDMA filter sequencer.
// Latency : n/a (types and a pure combinational function).
// Backpressure: n/a.
package udma_filter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } filt_state_e;

    typedef enum logic [2:0] {
        MODE_TX0_RX         = 3'd0,
        MODE_TX0_BIN_RX     = 3'd1,
        MODE_DUAL_AU_RX     = 3'd2,
        MODE_DUAL_AU_BIN_RX = 3'd3,
        MODE_TX0_AU_RX      = 3'd4,
        MODE_TX0_AU_BIN_RX  = 3'd5,
        MODE_TX0_BIN        = 3'd6,
        MODE_ILLEGAL        = 3'd7
    } filt_mode_e;

    typedef struct packed {
        logic tx0;
        logic tx1;
        logic au;
        logic bincu;
        logic rx;
    } filt_route_t;

    // Which channels are launched and which datapath stages are in path for a mode.
    // The illegal mode decodes to an empty route.
    function automatic filt_route_t decode_mode(input filt_mode_e mode);
        filt_route_t r;
        r = '0;
        case (mode)
            MODE_TX0_RX:         begin r.tx0 = 1'b1; r.rx = 1'b1; end
            MODE_TX0_BIN_RX:     begin r.tx0 = 1'b1; r.bincu = 1'b1; r.rx = 1'b1; end
            MODE_DUAL_AU_RX:     begin r.tx0 = 1'b1; r.tx1 = 1'b1; r.au = 1'b1; r.rx = 1'b1; end
            MODE_DUAL_AU_BIN_RX: begin r.tx0 = 1'b1; r.tx1 = 1'b1; r.au = 1'b1; r.bincu = 1'b1; r.rx = 1'b1; end
            MODE_TX0_AU_RX:      begin r.tx0 = 1'b1; r.au = 1'b1; r.rx = 1'b1; end
            MODE_TX0_AU_BIN_RX:  begin r.tx0 = 1'b1; r.au = 1'b1; r.bincu = 1'b1; r.rx = 1'b1; end
            MODE_TX0_BIN:        begin r.tx0 = 1'b1; r.bincu = 1'b1; end
            default:             r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/udma_filter_wdog.sv
// Purpose : saturating inactivity counter; flags expiry when it reaches limit-1 (limit 0 disables).
// Latency : expire_o is combinational from the counter state; clear takes effect next cycle.
// Backpressure: none; a clear in the same cycle suppresses expiry.
module udma_filter_wdog
    import udma_filter_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         expire_o
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Reload on clear, count while enabled, hold at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && !clr_i && (limit_i != '0) && (cnt_q == (limit_i - ONE));

endmodule

// File: rtl/udma_filter_sched.sv
// Purpose : sequences one filter job: launch channels, collect dones, drain pipeline, report outcome.
// Latency : start -> channel launch 1 cycle; last done -> evt_done DRAIN_CYCLES+2 cycles.
// Backpressure: none; a start while busy is rejected with evt_err, abort returns to IDLE silently.
module udma_filter_sched
    import udma_filter_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned TIMEOUT_W    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [2:0]           cfg_filter_mode_i,
    input  logic                 cfg_filter_start_i,
    input  logic                 cfg_abort_i,
    input  logic [TIMEOUT_W-1:0] cfg_timeout_i,
    output logic                 tx0_start_o,
    output logic                 tx1_start_o,
    output logic                 rx_start_o,
    input  logic                 tx0_done_i,
    input  logic                 tx1_done_i,
    input  logic                 rx_done_i,
    output logic                 au_en_o,
    output logic                 bincu_en_o,
    input  logic                 bincu_evt_i,
    output logic                 busy_o,
    output logic                 evt_done_o,
    output logic                 evt_err_o,
    output logic                 evt_bincu_o
);

    localparam int unsigned     DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0]   DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [DW-1:0]   DRAIN_ONE  = DW'(1);

    filt_state_e state_q, state_d;
    filt_route_t route_q, route_d;
    logic [2:0]    flags_q, flags_d;        // {tx0, tx1, rx} sticky dones
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic tx0_start_q, tx0_start_d;
    logic tx1_start_q, tx1_start_d;
    logic rx_start_q, rx_start_d;
    logic au_en_q, au_en_d;
    logic bincu_en_q, bincu_en_d;
    logic busy_q, busy_d;
    logic evt_done_q, evt_done_d;
    logic evt_err_q, evt_err_d;

    logic [2:0] need;
    logic [2:0] done_req;
    logic       wdog_clr;
    logic       wdog_expire;

    // Only dones of channels the latched mode actually uses count.
    assign need     = {route_q.tx0, route_q.tx1, route_q.rx};
    assign done_req = {tx0_done_i, tx1_done_i, rx_done_i} & need;
    assign wdog_clr = (state_q != RUN) || (done_req != 3'b000);

    udma_filter_wdog #(.W(TIMEOUT_W)) u_wdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (wdog_clr),
        .en_i     (state_q == RUN),
        .limit_i  (cfg_timeout_i),
        .expire_o (wdog_expire)
    );

    // Next state, sticky flags, drain count and the registered output values.
    always_comb begin
        state_d     = state_q;
        route_d     = route_q;
        flags_d     = flags_q;
        drain_cnt_d = drain_cnt_q;
        evt_done_d  = 1'b0;
        evt_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_filter_start_i) begin
                    if (filt_mode_e'(cfg_filter_mode_i) == MODE_ILLEGAL) begin
                        evt_err_d = 1'b1;
                    end else begin
                        route_d = decode_mode(filt_mode_e'(cfg_filter_mode_i));
                        state_d = ARM;
                    end
                end
            end
            ARM: begin
                // Old flags are dropped, but a done landing in the launch cycle is kept.
                flags_d = done_req;
                state_d = RUN;
            end
            RUN: begin
                flags_d = flags_q | done_req;
                // Completion is judged on registered flags and wins over a same-cycle expiry.
                if ((flags_q & need) == need) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end else if (wdog_expire) begin
                    state_d   = IDLE;
                    evt_err_d = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d    = DONE;
                    evt_done_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if ((state_q != IDLE) && cfg_filter_start_i) begin
            evt_err_d = 1'b1;
        end
        // Abort overrides every other outcome and stays silent.
        if ((state_q != IDLE) && cfg_abort_i) begin
            state_d    = IDLE;
            evt_done_d = 1'b0;
            evt_err_d  = 1'b0;
        end
        busy_d      = (state_d != IDLE);
        tx0_start_d = (state_d == ARM) && route_d.tx0;
        tx1_start_d = (state_d == ARM) && route_d.tx1;
        rx_start_d  = (state_d == ARM) && route_d.rx;
        au_en_d     = busy_d && route_d.au;
        bincu_en_d  = busy_d && route_d.bincu;
    end

    // FSM and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            route_q     <= '0;
            flags_q     <= '0;
            drain_cnt_q <= '0;
            tx0_start_q <= 1'b0;
            tx1_start_q <= 1'b0;
            rx_start_q  <= 1'b0;
            au_en_q     <= 1'b0;
            bincu_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            evt_done_q  <= 1'b0;
            evt_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            route_q     <= route_d;
            flags_q     <= flags_d;
            drain_cnt_q <= drain_cnt_d;
            tx0_start_q <= tx0_start_d;
            tx1_start_q <= tx1_start_d;
            rx_start_q  <= rx_start_d;
            au_en_q     <= au_en_d;
            bincu_en_q  <= bincu_en_d;
            busy_q      <= busy_d;
            evt_done_q  <= evt_done_d;
            evt_err_q   <= evt_err_d;
        end
    end

    assign tx0_start_o = tx0_start_q;
    assign tx1_start_o = tx1_start_q;
    assign rx_start_o  = rx_start_q;
    assign au_en_o     = au_en_q;
    assign bincu_en_o  = bincu_en_q;
    assign busy_o      = busy_q;
    assign evt_done_o  = evt_done_q;
    assign evt_err_o   = evt_err_q;
    assign evt_bincu_o = bincu_evt_i && busy_q && bincu_en_q;

endmodule

// File: tb/tb_udma_filter_sched.sv
// Purpose : self-checking bench for udma_filter_sched (mode table, directed corners, random jobs).
// Latency : cycle k of a job is the k-th clock after the start cycle; outputs sampled 1ns after the edge.
// Backpressure: n/a.
module tb_udma_filter_sched;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [2:0]  mode_i;
    logic        start_i, abort_i;
    logic [15:0] tmo_i;
    logic        tx0_s, tx1_s, rx_s;
    logic        tx0_d, tx1_d, rx_d;
    logic        au_en, bincu_en, bincu_i, busy;
    logic        evt_done, evt_err, evt_bincu;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    udma_filter_sched #(.DRAIN_CYCLES(D), .TIMEOUT_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cfg_filter_mode_i(mode_i), .cfg_filter_start_i(start_i),
        .cfg_abort_i(abort_i), .cfg_timeout_i(tmo_i),
        .tx0_start_o(tx0_s), .tx1_start_o(tx1_s), .rx_start_o(rx_s),
        .tx0_done_i(tx0_d), .tx1_done_i(tx1_d), .rx_done_i(rx_d),
        .au_en_o(au_en), .bincu_en_o(bincu_en), .bincu_evt_i(bincu_i),
        .busy_o(busy), .evt_done_o(evt_done), .evt_err_o(evt_err), .evt_bincu_o(evt_bincu)
    );

    typedef struct {
        logic [2:0] mode;
        logic [7:0] exp;   // {busy, done, err, tx0_start, tx1_start, rx_start, au_en, bincu_en} in cycle 1
    } vec_t;

    typedef struct {
        logic [2:0]  mode;
        int          tmo;
        int          d_tx0, d_tx1, d_rx;   // cycle of the done pulse, 0 = never
        int          abort_at;             // 0 = none
        int          start2_at;            // 0 = none
        int          bincu_at;             // 0 = none
        logic [63:0] bmask;                // extra random bincu pulses
    } job_t;

    function automatic logic [7:0] outv();
        return {busy, evt_done, evt_err, tx0_s, tx1_s, rx_s, au_en, bincu_en};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start_i = 0; abort_i = 0; tx0_d = 0; tx1_d = 0; rx_d = 0; bincu_i = 0;
    endtask

    // {tx0, tx1, au, bincu, rx} from the mode list: TX0 in every legal mode,
    // TX1 only for the dual-input AU modes, RX everywhere except mode 6.
    function automatic logic [4:0] route_of(input logic [2:0] m);
        logic tx0, tx1, au, bin, rx;
        tx0 = (m != 3'd7);
        tx1 = (m == 3'd2) || (m == 3'd3);
        au  = (m >= 3'd2) && (m <= 3'd5);
        bin = (m == 3'd1) || (m == 3'd3) || (m == 3'd5) || (m == 3'd6);
        rx  = (m <= 3'd5);
        return {tx0, tx1, au, bin, rx};
    endfunction

    // Outcome of a job from event times: returns the first idle cycle and event cycles (-1 = none).
    function automatic void model(input job_t j, output int busy_end, output int e_done,
                                  output int e_err1, output int e_err2);
        logic [4:0] rt;
        int q[$];
        int L, r, tmo_c, E, ev;
        bit complete, aborted;
        rt = route_of(j.mode);
        e_done = -1; e_err1 = -1; e_err2 = -1;
        if (j.mode == 3'd7) begin
            busy_end = 1;
            e_err1   = 1;
            return;
        end
        complete = 1;
        if (rt[4]) begin if (j.d_tx0 == 0) complete = 0; else q.push_back(j.d_tx0); end
        if (rt[3]) begin if (j.d_tx1 == 0) complete = 0; else q.push_back(j.d_tx1); end
        if (rt[0]) begin if (j.d_rx  == 0) complete = 0; else q.push_back(j.d_rx);  end
        q.sort();
        L = 1;
        foreach (q[i]) if (q[i] > L) L = q[i];
        // Watchdog: RUN starts at cycle 2 with a zero count; a required done in cycle t
        // restarts the count from cycle t+1. Expiry lands T-1 cycles after the restart.
        tmo_c = -1;
        r = 2;
        if (j.tmo != 0) begin
            foreach (q[i]) begin
                if (tmo_c < 0 && q[i] >= 2) begin
                    if (r + j.tmo - 1 < q[i]) tmo_c = r + j.tmo - 1;
                    else r = q[i] + 1;
                end
            end
            if (tmo_c < 0 && !complete) tmo_c = r + j.tmo - 1;
        end
        E  = L + 2 + D;
        ev = (tmo_c >= 0) ? tmo_c + 1 : (complete ? E : 1000000);
        aborted = (j.abort_at >= 1) && (j.abort_at < ev);
        if (aborted)         busy_end = j.abort_at + 1;
        else if (tmo_c >= 0) busy_end = tmo_c + 1;
        else                 busy_end = E + 1;
        if (!aborted && tmo_c >= 0) e_err1 = tmo_c + 1;
        if (!aborted && tmo_c < 0)  e_done = E;
        if (j.start2_at >= 1 && j.start2_at < busy_end && j.start2_at != j.abort_at)
            e_err2 = j.start2_at + 1;
    endfunction

    task automatic run_job(input job_t j, output int od, output int oe, output int oend, output int obin);
        int busy_end, e_done, e_err1, e_err2;
        logic [4:0] rt;
        logic [7:0] exp_v;
        logic b;
        rt = route_of(j.mode);
        model(j, busy_end, e_done, e_err1, e_err2);
        if (busy_end > 400) begin
            n_cmp++; n_fail++;
            $display("FAIL job_bound: model end %0d beyond budget 400", busy_end);
            busy_end = 400;
        end
        od = -1; oe = -1; oend = -1; obin = 0;
        tmo_i   = 16'(j.tmo);
        mode_i  = j.mode;
        start_i = 1;
        tick();
        for (int k = 1; k <= busy_end + 1; k++) begin
            b = (k < busy_end);
            exp_v = {b, k == e_done, (k == e_err1) || (k == e_err2),
                     (k == 1) && rt[4], (k == 1) && rt[3], (k == 1) && rt[0],
                     b && rt[2], b && rt[1]};
            chk($sformatf("job_out m%0d c%0d", j.mode, k), {24'd0, outv()}, {24'd0, exp_v});
            if (evt_done && od < 0) od = k;
            if (evt_err && oe < 0)  oe = k;
            if (!busy && oend < 0)  oend = k;
            start_i = (j.start2_at == k) && (k < busy_end);
            mode_i  = 3'($urandom_range(0, 7));
            abort_i = (j.abort_at == k);
            tx0_d   = (j.d_tx0 == k);
            tx1_d   = (j.d_tx1 == k);
            rx_d    = (j.d_rx == k);
            bincu_i = (j.bincu_at == k) || ((k < 64) && j.bmask[k[5:0]]);
            #1;
            chk($sformatf("evt_bincu m%0d c%0d", j.mode, k), {31'd0, evt_bincu},
                {31'd0, bincu_i && b && rt[1]});
            if (evt_bincu) obin++;
            tick();
        end
        idle_inputs();
    endtask

    function automatic job_t mk(input logic [2:0] m, input int t, input int a, input int b, input int c);
        job_t j;
        j.mode = m; j.tmo = t; j.d_tx0 = a; j.d_tx1 = b; j.d_rx = c;
        j.abort_at = 0; j.start2_at = 0; j.bincu_at = 0; j.bmask = '0;
        return j;
    endfunction

    vec_t tbl[8];

    initial begin
        job_t j;
        int od, oe, oend, obin;
        logic [4:0] rt;
        bit missing;

        tbl[0] = '{3'd0, 8'b1001_0100};
        tbl[1] = '{3'd1, 8'b1001_0101};
        tbl[2] = '{3'd2, 8'b1001_1110};
        tbl[3] = '{3'd3, 8'b1001_1111};
        tbl[4] = '{3'd4, 8'b1001_0110};
        tbl[5] = '{3'd5, 8'b1001_0111};
        tbl[6] = '{3'd6, 8'b1001_0001};
        tbl[7] = '{3'd7, 8'b0010_0000};

        rst_i = 1; mode_i = 0; tmo_i = 0;
        idle_inputs();
        tick(); tick(); tick();
        chk("reset_outputs", {24'd0, outv()}, 32'd0);
        bincu_i = 1; #1;
        chk("reset_evt_bincu", {31'd0, evt_bincu}, 32'd0);
        bincu_i = 0;
        rst_i = 0;
        tick();

        // Mode table: launch pattern and enables in the ARM cycle, then abort back to idle.
        for (int i = 0; i < 8; i++) begin
            mode_i = tbl[i].mode; start_i = 1;
            tick();
            start_i = 0;
            chk($sformatf("tbl_arm m%0d", i), {24'd0, outv()}, {24'd0, tbl[i].exp});
            abort_i = 1;
            tick();
            abort_i = 0;
            chk($sformatf("tbl_after m%0d", i), {24'd0, outv()}, 32'd0);
            tick();
        end

        // Staggered dual-input job: done 1+DRAIN+1 cycles after the last done.
        j = mk(3'd2, 0, 5, 9, 12);
        run_job(j, od, oe, oend, obin);
        chk_int("m2_done_cycle", od, 18);
        chk_int("m2_no_err", oe, -1);

        // Watchdog of 10 with no dones: RUN cycles 2..11, error reported in cycle 12.
        j = mk(3'd0, 10, 0, 0, 0);
        run_job(j, od, oe, oend, obin);
        chk_int("tmo_err_cycle", oe, 12);
        chk_int("tmo_idle_cycle", oend, 12);
        chk_int("tmo_no_done", od, -1);

        // Watchdog off: stays busy until abort.
        j = mk(3'd0, 0, 0, 0, 0);
        j.abort_at = 50;
        run_job(j, od, oe, oend, obin);
        chk_int("nowdog_idle_cycle", oend, 51);
        chk_int("nowdog_no_err", oe, -1);

        // Mode 6: second start rejected, RX done ignored, TX0 done completes.
        j = mk(3'd6, 0, 8, 0, 6);
        j.start2_at = 4;
        run_job(j, od, oe, oend, obin);
        chk_int("m6_busy_start_err", oe, 5);
        chk_int("m6_done_cycle", od, 14);

        // BINCU event passes only when BINCU is in path and busy.
        j = mk(3'd3, 0, 3, 3, 3);
        j.bincu_at = 4;
        run_job(j, od, oe, oend, obin);
        chk_int("m3_bincu_count", obin, 1);
        chk_int("m3_done_cycle", od, 9);
        j = mk(3'd0, 0, 3, 0, 3);
        j.bincu_at = 4;
        run_job(j, od, oe, oend, obin);
        chk_int("m0_bincu_count", obin, 0);

        // Abort together with the final done.
        j = mk(3'd1, 0, 3, 0, 6);
        j.abort_at = 6;
        run_job(j, od, oe, oend, obin);
        chk_int("abort_no_done", od, -1);
        chk_int("abort_no_err", oe, -1);
        chk_int("abort_idle_cycle", oend, 7);

        // Reset while draining.
        mode_i = 3'd0; start_i = 1; tmo_i = 0;
        tick();
        start_i = 0; tx0_d = 1; rx_d = 1;
        tick();
        tx0_d = 0; rx_d = 0;
        tick(); tick();
        chk("drain_busy", {24'd0, outv()}, 32'h80);
        rst_i = 1;
        tick();
        chk("rst_drain_out", {24'd0, outv()}, 32'd0);
        tick();
        rst_i = 0;
        tick();
        chk("rst_drain_after", {24'd0, outv()}, 32'd0);
        tick(); tick();
        chk("rst_drain_quiet", {24'd0, outv()}, 32'd0);

        // Random jobs.
        for (int n = 0; n < 60; n++) begin
            j.mode      = 3'($urandom_range(0, 7));
            j.tmo       = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 25));
            j.d_tx0     = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 30));
            j.d_tx1     = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 30));
            j.d_rx      = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 30));
            j.abort_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0;
            j.start2_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0;
            j.bincu_at  = 0;
            j.bmask     = {$urandom, $urandom};
            rt = route_of(j.mode);
            missing = (rt[4] && j.d_tx0 == 0) || (rt[3] && j.d_tx1 == 0) || (rt[0] && j.d_rx == 0);
            if (j.mode != 3'd7 && j.tmo == 0 && j.abort_at == 0 && missing)
                j.abort_at = $urandom_range(1, 40);
            run_job(j, od, oe, oend, obin);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: bench did not finish, %0d compared so far", n_cmp);
        $fatal(1);
    end

endmodule
